// File: rtl/mul_seq_pkg.sv
// Shared constants for the shift-add multiply sequencer: FSM encoding,
// counter sizing and the half-width operand mask.
package mul_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [63:0] HALF_MASK = 64'h00000000FFFFFFFF;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mul_seq_datapath.sv
// Iteration datapath: accumulator, shifting multiplicand/multiplier and the
// iteration counter. The operand size is captured at load so a run is self-contained.
module mul_seq_datapath
  import mul_seq_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         size64,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] acc_next,
  output logic         mplier_zero_next,
  output logic         last_iter,
  output logic         wide
);

  localparam int CW = cnt_width(N);
  localparam logic [N-1:0] MASK = N'(HALF_MASK);

  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  mplier_shift;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  // Carry-out of the add is dropped: only the low N product bits are kept.
  assign acc_next         = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shift     = mplier >> 1;
  assign mplier_zero_next = (mplier_shift == '0);
  assign limit            = wide ? CW'(N) : CW'(N / 2);
  assign last_iter        = ((cnt + CW'(1)) == limit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      wide   <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= size64 ? op_a : (op_a & MASK);
      mplier <= size64 ? op_b : (op_b & MASK);
      cnt    <= '0;
      wide   <= size64;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier_shift;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multiply sequencer replacing the MUL microcode: IDLE/RUN/DONE control,
// product register and the stall/busy/done handshake to the control unit.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int N          = 64,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         size64,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         stall,
  output logic [1:0]   state
);

  localparam logic [N-1:0] MASK = N'(HALF_MASK);

  logic [1:0]   state_q;
  logic         load;
  logic         step;
  logic         finish;
  logic [N-1:0] acc_next;
  logic         mplier_zero_next;
  logic         last_iter;
  logic         wide;

  assign load   = (state_q == ST_IDLE) && start;
  assign step   = (state_q == ST_RUN) && !abort;
  assign finish = step && (last_iter || ((EARLY_EXIT != 0) && mplier_zero_next));

  // Stall is combinational so the control unit freezes in the start cycle itself.
  assign stall = reset && ((state_q == ST_RUN) || load);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

  mul_seq_datapath #(.N(N)) u_datapath (
    .clock            (clock),
    .reset            (reset),
    .load             (load),
    .step             (step),
    .size64           (size64),
    .op_a             (op_a),
    .op_b             (op_b),
    .acc_next         (acc_next),
    .mplier_zero_next (mplier_zero_next),
    .last_iter        (last_iter),
    .wide             (wide)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      result  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_q <= ST_RUN;
        ST_RUN: begin
          // Abort wins over a completion landing on the same edge.
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (finish) begin
            state_q <= ST_DONE;
            result  <= wide ? acc_next : (acc_next & MASK);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
